seq_memory_stage: RTL and testbench

Memory stage of the SEQ Y86-64 processor. It sits between execute and writeback: it takes icode, valA, valE and valP, then performs the data-memory read or write for the instruction. It returns valM and the instruction status to the writeback stage and the PC-update logic. The internal data memory has a configurable multi-cycle latency, controlled by a start/done handshake.

---
 rtl/seq_memory_stage.sv | 158 +++++++++++++++
 tb/tb_seq_memory_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_memory_stage.sv
// Purpose: SEQ Y86-64 memory stage; data-memory read/write per icode, returns valM/stat.
// Latency: memory ops complete LATENCY cycles after start, non-memory/illegal ops after 1 cycle.
// Backpressure: start is ignored while busy; one instruction in flight, done pulses once per accept.
module seq_memory_stage #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic [2:0]  stat,
    output logic        done,
    output logic        busy
);

    localparam int          IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;

    // Latched, already-decoded view of the accepted instruction
    logic            op_wr, op_rd;
    logic [IW-1:0]   op_idx;
    logic [63:0]     op_wdata;
    logic [2:0]      op_stat;

    // Held results of the most recently completed instruction
    logic [63:0]     valm_q;
    logic [2:0]      stat_q;

    // Decode of the incoming instruction, only consumed when start is accepted
    logic [63:0]     dec_addr, dec_wdata;
    logic            dec_wr, dec_rd, dec_legal;
    logic [2:0]      dec_stat;

    // Response presented during the done cycle
    logic [63:0]     resp_valm;
    logic [2:0]      resp_stat;

    // Contents survive reset; zero at power-up only
    logic [63:0]     mem [MEM_WORDS] = '{default: '0};

    // Classify icode and pick address / write data
    always_comb begin
        dec_addr  = valE;
        dec_wdata = valA;
        dec_wr    = 1'b0;
        dec_rd    = 1'b0;
        dec_stat  = STAT_AOK;
        case (icode)
            4'h0:                         dec_stat = STAT_HLT;
            4'h1, 4'h2, 4'h3, 4'h6, 4'h7: dec_stat = STAT_AOK;
            4'h4, 4'hA:                   dec_wr   = 1'b1;
            4'h5:                         dec_rd   = 1'b1;
            4'h8: begin
                dec_wr    = 1'b1;
                dec_wdata = valP;
            end
            4'h9, 4'hB: begin
                dec_rd   = 1'b1;
                dec_addr = valA;
            end
            default:                      dec_stat = STAT_INS;
        endcase
        dec_legal = (dec_addr[2:0] == 3'b000) && (dec_addr < MEM_BYTES);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, done pulse and the response for the done cycle; reset suppresses done
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        resp_valm = '0;
        resp_stat = STAT_AOK;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = ((dec_wr || dec_rd) && dec_legal) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    resp_valm = op_rd ? mem[op_idx] : 64'd0;
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                done      = 1'b1;
                resp_stat = op_stat;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            state_nxt = IDLE;
            done      = 1'b0;
        end
    end

    // Accept instruction, run the latency counter, hold results after done
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_wr    <= 1'b0;
            op_rd    <= 1'b0;
            op_idx   <= '0;
            op_wdata <= '0;
            op_stat  <= STAT_AOK;
            valm_q   <= '0;
            stat_q   <= STAT_AOK;
        end else begin
            if (state == IDLE && start) begin
                op_wr    <= dec_wr && dec_legal;
                op_rd    <= dec_rd && dec_legal;
                op_idx   <= dec_addr[IW+2:3];
                op_wdata <= dec_wdata;
                op_stat  <= ((dec_wr || dec_rd) && !dec_legal) ? STAT_ADR : dec_stat;
                cnt      <= CW'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                valm_q <= resp_valm;
                stat_q <= resp_stat;
            end
        end
    end

    // Commit the write on the done edge of a legal store
    always_ff @(posedge clk) begin
        if (done && state == WAIT && op_wr)
            mem[op_idx] <= op_wdata;
    end

    assign valM = done ? resp_valm : valm_q;
    assign stat = done ? resp_stat : stat_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_memory_stage.sv
// Purpose: directed self-checking bench for seq_memory_stage (MEM_WORDS=1024, LATENCY=2).
// Latency: checks done timing per instruction class and back-to-back spacing.
// Backpressure: checks starts dropped while busy and reset aborting an in-flight write.
module tb_seq_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic [63:0] valM;
    logic [2:0]  stat;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cyc;

    seq_memory_stage #(.MEM_WORDS(1024), .LATENCY(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .icode (icode),
        .valA  (valA),
        .valE  (valE),
        .valP  (valP),
        .valM  (valM),
        .stat  (stat),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction on the next cycle and wait (bounded) for done
    task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, output logic [63:0] vm, output logic [2:0] st,
                         output int lat);
        @(negedge clk);
        icode = ic; valA = a; valE = e; valP = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        vm = valM;
        st = stat;
        done_cyc = cyc;
    endtask

    task automatic run_op(input string tag, input logic [3:0] ic, input logic [63:0] a,
                          input logic [63:0] e, input logic [63:0] p, input int exp_lat,
                          input logic [63:0] exp_vm, input logic [2:0] exp_st);
        logic [63:0] vm;
        logic [2:0]  st;
        int          lat;
        do_op(ic, a, e, p, vm, st, lat);
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_valM"}, vm, exp_vm);
        chk({tag, "_stat"}, 64'(st), 64'(exp_st));
    endtask

    function automatic logic [63:0] exp_word(input int i);
        case (i)
            2:       return 64'hDEADBEEF;
            62:      return 64'd7;
            63:      return 64'h40;
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        logic [63:0] vm;
        logic [2:0]  st;
        int          lat;
        int          bad;
        int          ndone;
        int          prev;

        rst = 1'b1; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        rst = 1'b0;

        // Basic store then load
        run_op("rmmov", 4'h4, 64'hDEADBEEF, 64'h10, 64'd0, 2, 64'd0, 3'd1);
        run_op("mrmov", 4'h5, 64'd0, 64'h10, 64'd0, 2, 64'hDEADBEEF, 3'd1);
        @(negedge clk);
        chk("hold_valM", valM, 64'hDEADBEEF);
        chk("hold_done", 64'(done), 64'd0);
        chk("hold_busy", 64'(busy), 64'd0);

        // Stack-style accesses
        run_op("call", 4'h8, 64'd0, 64'h1F8, 64'h40, 2, 64'd0, 3'd1);
        run_op("ret",  4'h9, 64'h1F8, 64'd0, 64'd0, 2, 64'h40, 3'd1);
        run_op("push", 4'hA, 64'd7, 64'h1F0, 64'd0, 2, 64'd0, 3'd1);
        run_op("pop",  4'hB, 64'h1F0, 64'd0, 64'd0, 2, 64'd7, 3'd1);

        // Illegal addresses
        run_op("misal", 4'h5, 64'd0, 64'h13, 64'd0, 1, 64'd0, 3'd3);
        run_op("oob",   4'h4, 64'hBAD, 64'd8192, 64'd0, 1, 64'd0, 3'd3);
        run_op("last",  4'h5, 64'd0, 64'd8184, 64'd0, 2, 64'd0, 3'd1);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            do_op(4'h5, 64'd0, 64'(i * 8), 64'd0, vm, st, lat);
            if (vm !== exp_word(i) || st !== 3'd1 || lat != 2) bad++;
        end
        chk("sweep_bad", 64'(bad), 64'd0);

        // Non-memory instructions
        run_op("pre_rd", 4'h5, 64'd0, 64'h10, 64'd0, 2, 64'hDEADBEEF, 3'd1);
        run_op("halt",   4'h0, 64'h123, 64'h08, 64'h123, 1, 64'd0, 3'd2);
        run_op("ins",    4'hD, 64'h123, 64'h08, 64'h123, 1, 64'd0, 3'd4);
        run_op("opq",    4'h6, 64'h123, 64'h08, 64'h123, 1, 64'd0, 3'd1);
        run_op("nomem",  4'h5, 64'd0, 64'h08, 64'd0, 2, 64'd0, 3'd1);

        // Back-to-back mixed: spacing = latency of next op + 1
        run_op("b2b0", 4'h5, 64'd0, 64'h10, 64'd0, 2, 64'hDEADBEEF, 3'd1);
        prev = done_cyc;
        run_op("b2b1", 4'h0, 64'd0, 64'd0, 64'd0, 1, 64'd0, 3'd2);
        chk("b2b1_gap", 64'(done_cyc - prev), 64'd2);
        prev = done_cyc;
        run_op("b2b2", 4'hB, 64'h1F0, 64'd0, 64'd0, 2, 64'd7, 3'd1);
        chk("b2b2_gap", 64'(done_cyc - prev), 64'd3);
        prev = done_cyc;
        run_op("b2b3", 4'h6, 64'd0, 64'd0, 64'd0, 1, 64'd0, 3'd1);
        chk("b2b3_gap", 64'(done_cyc - prev), 64'd2);

        // Start while busy is dropped
        @(negedge clk);
        icode = 4'h4; valA = 64'h55; valE = 64'h20; start = 1'b1;
        @(negedge clk);
        chk("busy_hi", 64'(busy), 64'd1);
        ndone = done ? 1 : 0;
        icode = 4'h4; valA = 64'h66; valE = 64'h28;
        @(negedge clk);
        start = 1'b0;
        repeat (7) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("busy_ndone", 64'(ndone), 64'd1);
        run_op("busy_rd20", 4'h5, 64'd0, 64'h20, 64'd0, 2, 64'h55, 3'd1);
        run_op("busy_rd28", 4'h5, 64'd0, 64'h28, 64'd0, 2, 64'd0, 3'd1);

        // Reset during WAIT aborts the store
        run_op("pre_rst", 4'h5, 64'd0, 64'h10, 64'd0, 2, 64'hDEADBEEF, 3'd1);
        @(negedge clk);
        icode = 4'h4; valA = 64'h99; valE = 64'h30; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_valM", valM, 64'd0);
        chk("post_rst_stat", 64'(stat), 64'd1);
        run_op("rst_rd30", 4'h5, 64'd0, 64'h30, 64'd0, 2, 64'd0, 3'd1);

        // Reset and start together: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; icode = 4'h4; valA = 64'h77; valE = 64'h38;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rs_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rs_done", 64'(done), 64'd0);
        run_op("rs_rd38", 4'h5, 64'd0, 64'h38, 64'd0, 2, 64'd0, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
